int_sqrt_seq: RTL and testbench

Parametrised sequential non-restoring integer square root with a handshaked result and cancel support. It generalises the fixed 32-bit root unit to any even operand width. Results are held until the consumer accepts them, and a one-cycle remainder correction is added. The block sits in the ALU extended-arithmetic cluster beside the divider and is driven by the multi-cycle issue logic.

---
 rtl/int_sqrt_pkg.sv | 7 +
 rtl/int_sqrt_seq_step.sv | 16 +
 rtl/int_sqrt_seq.sv | 106 ++++++++++
 tb/tb_int_sqrt_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_sqrt_pkg.sv
// int_sqrt_pkg: shared state encoding and width check for the square-root unit.
package int_sqrt_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;
  function automatic bit width_ok(input int w);
    return (w % 2 == 0) && (w >= 4);
  endfunction
endpackage

// File: rtl/int_sqrt_seq_step.sv
// sqrt_nr_step: one combinational non-restoring square-root iteration.
module sqrt_nr_step #(
  parameter int QW = 16
) (
  input  logic [QW+1:0] i_rem,
  input  logic [QW-1:0] i_root,
  input  logic [1:0]    i_bits,
  output logic [QW+1:0] o_rem,
  output logic [QW-1:0] o_root
);
  logic [QW+1:0] w_sh;
  // |rem| stays below 2^QW, so the bits shifted out are pure sign extension
  assign w_sh   = (QW+2)'({i_rem, i_bits});
  assign o_rem  = i_rem[QW+1] ? w_sh + {i_root, 2'b11} : w_sh - {i_root, 2'b01};
  assign o_root = {i_root[QW-2:0], ~o_rem[QW+1]};
endmodule

// File: rtl/int_sqrt_seq.sv
// int_sqrt_seq: sequential non-restoring integer square root with result handshake and cancel.
// Optional round-to-nearest output q_rnd is enabled by defining INT_SQRT_ROUND_EN.
module int_sqrt_seq
  import int_sqrt_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int QW    = WIDTH / 2,
  localparam int CW    = $clog2(WIDTH / 2)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             cancel,
  input  logic             ack,
  output logic [QW-1:0]    q,
  output logic [QW:0]      r,
`ifdef INT_SQRT_ROUND_EN
  output logic [QW:0]      q_rnd,
`endif
  output logic             busy,
  output logic             ready,
  output logic [CW-1:0]    count
);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("int_sqrt_seq: WIDTH must be even and at least 4");
  end
  state_t          r_state;
  logic [WIDTH-1:0] r_d;
  logic [QW+1:0]   r_rem;
  logic [QW-1:0]   r_root;
  logic [QW+1:0]   w_rem;
  logic [QW-1:0]   w_root;
  logic [QW:0]     w_fix;
  sqrt_nr_step #(.QW(QW)) u_step (
    .i_rem  (r_rem),
    .i_root (r_root),
    .i_bits (r_d[WIDTH-1:WIDTH-2]),
    .o_rem  (w_rem),
    .o_root (w_root)
  );
  // the corrected remainder fits in QW+1 bits, so the sign bit can be dropped
  assign w_fix = r_rem[QW+1] ? r_rem[QW:0] + {r_root, 1'b1} : r_rem[QW:0];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_d     <= '0;
      r_rem   <= '0;
      r_root  <= '0;
      q       <= '0;
      r       <= '0;
`ifdef INT_SQRT_ROUND_EN
      q_rnd   <= '0;
`endif
      busy    <= 1'b0;
      ready   <= 1'b0;
      count   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (load) begin
            r_d     <= d;
            r_rem   <= '0;
            r_root  <= '0;
            count   <= CW'(QW - 1);
            busy    <= 1'b1;
            ready   <= 1'b0;
            r_state <= S_ITER;
          end else if (r_state == S_DONE && ack) begin
            ready   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ITER: begin
          if (cancel) begin
            busy    <= 1'b0;
            count   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_rem  <= w_rem;
            r_root <= w_root;
            r_d    <= {r_d[WIDTH-3:0], 2'b00};
            if (count == '0) r_state <= S_FIX;
            else count <= count - CW'(1);
          end
        end
        S_FIX: begin
          if (cancel) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            q       <= r_root;
            r       <= w_fix;
`ifdef INT_SQRT_ROUND_EN
            q_rnd   <= (w_fix > {1'b0, r_root}) ? {1'b0, r_root} + (QW+1)'(1) : {1'b0, r_root};
`endif
            busy    <= 1'b0;
            ready   <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_sqrt_seq.sv
// tb_int_sqrt_seq: directed self-checking bench for int_sqrt_seq at WIDTH=32 and WIDTH=8.
module tb_int_sqrt_seq;
  logic        clock = 1'b0, resetn = 1'b0, load = 1'b0, cancel = 1'b0, ack = 1'b0;
  logic [31:0] d = '0;
  logic [15:0] q;
  logic [16:0] r;
  logic        busy, ready;
  logic [3:0]  count;
  logic        load8 = 1'b0, ack8 = 1'b0, cancel8 = 1'b0;
  logic [7:0]  d8 = '0;
  logic [3:0]  q8;
  logic [4:0]  r8;
  logic        busy8, ready8;
  logic [1:0]  count8;
`ifdef INT_SQRT_ROUND_EN
  logic [16:0] q_rnd;
  logic [4:0]  q_rnd8;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  int_sqrt_seq #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .load(load), .d(d), .cancel(cancel), .ack(ack),
    .q(q), .r(r),
`ifdef INT_SQRT_ROUND_EN
    .q_rnd(q_rnd),
`endif
    .busy(busy), .ready(ready), .count(count)
  );

  int_sqrt_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .resetn(resetn), .load(load8), .d(d8), .cancel(cancel8), .ack(ack8),
    .q(q8), .r(r8),
`ifdef INT_SQRT_ROUND_EN
    .q_rnd(q_rnd8),
`endif
    .busy(busy8), .ready(ready8), .count(count8)
  );

  // leaves the bench on the negedge right after the accepting edge
  task automatic start32(input logic [31:0] v);
    @(negedge clock);
    d = v;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    d = ~v;
  endtask

  task automatic wait_ready32(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (ready) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic pulse_ack;
    @(negedge clock);
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (q !== 0 || r !== 0 || busy !== 0 || ready !== 0 || count !== 0) begin
      n_bad++;
      $display("FAIL reset32: q=%h r=%h busy=%b ready=%b count=%0d required all zero", q, r, busy, ready, count);
    end
    n_cmp++;
    if (q8 !== 0 || r8 !== 0 || busy8 !== 0 || ready8 !== 0 || count8 !== 0) begin
      n_bad++;
      $display("FAIL reset8: q=%h r=%h busy=%b ready=%b count=%0d required all zero", q8, r8, busy8, ready8, count8);
    end
`ifdef INT_SQRT_ROUND_EN
    n_cmp++;
    if (q_rnd !== 0) begin
      n_bad++;
      $display("FAIL reset_q_rnd: got %h required 0", q_rnd);
    end
`endif
  endtask

  task automatic test_basic;
    int nb = 1, cyc = -1;
    start32(32'hC000_0000);
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0 || count !== 4'd15) begin
      n_bad++;
      $display("FAIL accept: busy=%b ready=%b count=%0d required 1 0 15", busy, ready, count);
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (busy) begin
        nb++;
        if (i <= 15) begin
          n_cmp++;
          if (count !== 4'(15 - i)) begin
            n_bad++;
            $display("FAIL count_step%0d: got %0d required %0d", i, count, 15 - i);
          end
        end
      end
      if (ready) begin
        cyc = i;
        break;
      end
    end
    n_cmp++;
    if (cyc !== 17) begin
      n_bad++;
      $display("FAIL latency: got %0d required 17", cyc);
    end
    n_cmp++;
    if (nb !== 17) begin
      n_bad++;
      $display("FAIL busy_cycles: got %0d required 17", nb);
    end
    n_cmp++;
    if (q !== 16'hDDB3 || r !== 17'h174D7) begin
      n_bad++;
      $display("FAIL basic_result: q=%h r=%h required ddb3 174d7", q, r);
    end
`ifdef INT_SQRT_ROUND_EN
    n_cmp++;
    if (q_rnd !== 17'hDDB4) begin
      n_bad++;
      $display("FAIL basic_q_rnd: got %h required ddb4", q_rnd);
    end
`endif
    pulse_ack();
  endtask

  task automatic test_vectors;
    logic [31:0] vd[4] = '{32'hFFFF_FFFF, 32'd0, 32'd16, 32'd15};
    logic [15:0] vq[4] = '{16'hFFFF, 16'd0, 16'd4, 16'd3};
    logic [16:0] vr[4] = '{17'h1FFFE, 17'd0, 17'd0, 17'd6};
    int n;
    for (int k = 0; k < 4; k++) begin
      start32(vd[k]);
      wait_ready32(n);
      n_cmp++;
      if (n !== 17 || q !== vq[k] || r !== vr[k]) begin
        n_bad++;
        $display("FAIL vec%0d: lat=%0d q=%h r=%h required 17 %h %h", k, n, q, r, vq[k], vr[k]);
      end
      repeat (3) @(negedge clock);
      n_cmp++;
      if (ready !== 1'b1 || q !== vq[k] || r !== vr[k]) begin
        n_bad++;
        $display("FAIL hold%0d: ready=%b q=%h r=%h required 1 %h %h", k, ready, q, r, vq[k], vr[k]);
      end
      pulse_ack();
      n_cmp++;
      if (ready !== 1'b0 || busy !== 1'b0 || q !== vq[k] || r !== vr[k]) begin
        n_bad++;
        $display("FAIL ack%0d: ready=%b busy=%b q=%h r=%h required 0 0 %h %h", k, ready, busy, q, r, vq[k], vr[k]);
      end
    end
  endtask

  task automatic test_w8;
    logic [7:0] vd[2] = '{8'hFF, 8'h40};
    logic [3:0] vq[2] = '{4'd15, 4'd8};
    logic [4:0] vr[2] = '{5'd30, 5'd0};
    logic [4:0] vn[2] = '{5'd16, 5'd8};
    int n;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      d8 = vd[k];
      load8 = 1'b1;
      @(negedge clock);
      load8 = 1'b0;
      n = -1;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clock);
        if (ready8) begin
          n = i;
          break;
        end
      end
      n_cmp++;
      if (n !== 5 || q8 !== vq[k] || r8 !== vr[k]) begin
        n_bad++;
        $display("FAIL w8_vec%0d: lat=%0d q=%0d r=%0d required 5 %0d %0d", k, n, q8, r8, vq[k], vr[k]);
      end
`ifdef INT_SQRT_ROUND_EN
      n_cmp++;
      if (q_rnd8 !== vn[k]) begin
        n_bad++;
        $display("FAIL w8_q_rnd%0d: got %0d required %0d", k, q_rnd8, vn[k]);
      end
`else
      if (vn[k] == 0) $display("note: unused rounding table");
`endif
      @(negedge clock);
      ack8 = 1'b1;
      @(negedge clock);
      ack8 = 1'b0;
    end
  endtask

  task automatic test_cancel;
    int n;
    start32(32'hC000_0000);
    repeat (5) @(negedge clock);
    cancel = 1'b1;
    @(negedge clock);
    cancel = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0 || q !== 16'd3 || r !== 17'd6) begin
      n_bad++;
      $display("FAIL cancel: busy=%b ready=%b q=%h r=%h required 0 0 3 6", busy, ready, q, r);
    end
    start32(32'd16);
    wait_ready32(n);
    n_cmp++;
    if (n !== 17 || q !== 16'd4 || r !== 17'd0) begin
      n_bad++;
      $display("FAIL after_cancel: lat=%0d q=%h r=%h required 17 4 0", n, q, r);
    end
    pulse_ack();
  endtask

  task automatic test_load_ignored;
    int n;
    start32(32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    d = 32'd16;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    wait_ready32(n);
    n_cmp++;
    if (n !== 12 || q !== 16'hFFFF || r !== 17'h1FFFE) begin
      n_bad++;
      $display("FAIL busy_load: lat=%0d q=%h r=%h required 12 ffff 1fffe", n, q, r);
    end
    @(negedge clock);
    d = 32'd0;
    load = 1'b1;
    ack = 1'b1;
    @(negedge clock);
    load = 1'b0;
    ack = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL done_load: busy=%b ready=%b required 1 0", busy, ready);
    end
    wait_ready32(n);
    n_cmp++;
    if (n !== 17 || q !== 16'd0 || r !== 17'd0) begin
      n_bad++;
      $display("FAIL done_load_result: lat=%0d q=%h r=%h required 17 0 0", n, q, r);
    end
    pulse_ack();
  endtask

  task automatic test_async_reset;
    int n;
    start32(32'hC000_0000);
    repeat (6) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    n_cmp++;
    if (q !== 0 || r !== 0 || busy !== 0 || ready !== 0 || count !== 0) begin
      n_bad++;
      $display("FAIL async_reset: q=%h r=%h busy=%b ready=%b count=%0d required all zero", q, r, busy, ready, count);
    end
    @(negedge clock);
    resetn = 1'b1;
    start32(32'hC000_0000);
    wait_ready32(n);
    n_cmp++;
    if (n !== 17 || q !== 16'hDDB3 || r !== 17'h174D7) begin
      n_bad++;
      $display("FAIL post_reset: lat=%0d q=%h r=%h required 17 ddb3 174d7", n, q, r);
    end
    pulse_ack();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    resetn = 1'b1;
    test_basic();
    test_vectors();
    test_w8();
    test_cancel();
    test_load_ignored();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
